uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver. It is the successor to the team's fixed 8N1 receiver and supports configurable data width, optional even/odd parity, and 1 or 2 stop bits. It adds a metastability synchroniser, false-start rejection, mid-bit sampling, and separate framing, parity and break reporting. It sits behind the shared baud tick generator (s_tick) and feeds the RX FIFO/register interface.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, s_tick pulses per bit period, even, legal 8..32
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, with PARITY_EN=1: 1 = odd parity, 0 = even parity
STOP_BITS, 1, stop bits checked per frame, legal 1 or 2

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous, active-low reset
enabled  in  1  receiver enable; low forces IDLE
in  in  1  asynchronous RX line, idles high
s_tick  in  1  one-clk oversample strobe
busy  out  1  high while a frame is in progress
done  out  1  one-clk pulse when a frame completes
frame_err  out  1  valid with done: a stop bit was sampled low
parity_err  out  1  valid with done: parity mismatch (always 0 if PARITY_EN=0)
break_det  out  1  valid with done: data, parity and first stop bit all 0
out  out  DATA_BITS  received word; updates only on done

Behaviour:
- Reset (rstN low, async): state IDLE, counters 0, synchroniser flops = 1, out = 0, busy/done/frame_err/parity_err/break_det = 0.
- Synchroniser: 2-flop on in; all logic uses the synchronised value rx_s. Line-to-logic latency is 2 clk.
- Counters: s (tick count, width clog2(OVERSAMPLE)); n (bit index, width clog2(DATA_BITS+1)). Both advance only on cycles with s_tick=1.
- Registered outputs: busy, done, the error flags and out update one clk after the state decision.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: enabled=1 and rx_s=0 -> START, s=0, busy=1.
- START: on s_tick with s==OVERSAMPLE/2-1, this is the mid-start sample.
  - rx_s=0 -> DATA, s=0, n=0.
  - rx_s=1 -> false start: back to IDLE, busy=0, no done, no error.
  - Otherwise s++.
- DATA: on s_tick with s==OVERSAMPLE-1 (mid-bit), shift rx_s into the MSB of the shift register (LSB-first), running parity ^= rx_s, s=0, n++.
  - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP.
- PARITY: mid-bit sample p. parity_err = (parity^p) != PARITY_ODD. Then -> STOP with n=0.
- STOP: mid-bit sample of each stop bit. Any sampled 0 sets frame_err.
  - After stop bit STOP_BITS: done=1 for one clk; out, frame_err, parity_err and break_det are presented in the same clk; busy=0; -> IDLE.
  - No wait for the end of the stop bit, so a start bit arriving half a bit later is still caught.
- break_det = all data bits 0, parity bit 0 (if enabled), and first stop bit 0. frame_err is also 1 in that case.
- Error flags are 0 whenever done=0. out holds its value between frames; a false start or abort never changes it.
- enabled falling mid-frame: abort to IDLE next clk, busy=0, no done, counters cleared.
- enabled held low: IDLE, busy=0, line ignored.
- Back-to-back frames: a start detected in the clk after done is legal and must not be missed.
- s_tick=0: FSM holds except for the IDLE start detect and the enabled abort.
- Async reset mid-frame: all outputs 0 immediately; the partial word is discarded.

Test Plan:
- 8N1 defaults, s_tick every clk, send 0xA5 -> exactly one done pulse, out=0xA5, all error flags 0, busy high for ~9.5 bit periods.
- Low glitch of 4 ticks on idle line -> START then IDLE, busy pulses, no done, out unchanged.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, send 0x41 with parity bit 1 wrong -> done, out=0x41, parity_err=1; resend with correct parity 0 -> parity_err=0.
- STOP_BITS=2, 8N2, second stop bit driven low -> done, frame_err=1, out correct.
- Line held low for 12 bit periods -> done with out=0x00, frame_err=1, break_det=1; no second frame until the line returns high and then falls again.
- 0x3C then 0xC3 sent back-to-back with minimum spacing, with enabled dropped mid-way through a third frame -> two done pulses with the correct values, third frame aborted with no done, busy=0 the clk after enabled falls.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Signal bundle between the oversampling UART receiver and its line, tick and RX-FIFO side.
// The receiver uses the slave modport; the driving environment uses master.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_enabled;
    logic                 i_in;
    logic                 i_s_tick;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_break_det;
    logic [DATA_BITS-1:0] o_out;

    modport slave (
        input  i_enabled, i_in, i_s_tick,
        output o_busy, o_done, o_frame_err, o_parity_err, o_break_det, o_out
    );

    modport master (
        output i_enabled, i_in, i_s_tick,
        input  o_busy, o_done, o_frame_err, o_parity_err, o_break_det, o_out
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-flop line synchroniser, false-start rejection,
// mid-bit sampling, optional parity, 1 or 2 stop bits, framing/parity/break reporting.
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rstN,
    uart_rx_param_if.slave bus
);
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned NW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_HALF      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_FULL      = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST_DATA = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_LAST_STOP = NW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [SW-1:0]        r_s;
    logic [NW-1:0]        r_n;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_zero;
    logic                 r_brk1;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_armed;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_break_det;
    logic [DATA_BITS-1:0] r_out;
    logic                 w_rx;
    logic                 w_brk;

    assign w_rx  = r_sync[1];
    // Break needs the first stop bit; with two stop bits it was captured one bit earlier.
    assign w_brk = (r_n == '0) ? (r_zero & ~w_rx) : r_brk1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_sync <= '1;
        else       r_sync <= {r_sync[0], bus.i_in};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_zero       <= 1'b0;
            r_brk1       <= 1'b0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_armed      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_break_det  <= 1'b0;
            r_out        <= '0;
        end else begin
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_break_det  <= 1'b0;
            // After a break the line must return high before a new start is accepted.
            if (w_rx) r_armed <= 1'b1;
            if (!bus.i_enabled) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_s     <= '0;
                r_n     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_armed && !w_rx) begin
                            r_state <= START;
                            r_s     <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (bus.i_s_tick) begin
                            if (r_s == S_HALF) begin
                                r_s <= '0;
                                if (!w_rx) begin
                                    r_state <= DATA;
                                    r_n     <= '0;
                                    r_par   <= 1'b0;
                                    r_zero  <= 1'b1;
                                    r_ferr  <= 1'b0;
                                    r_perr  <= 1'b0;
                                end else begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_s <= r_s + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.i_s_tick) begin
                            if (r_s == S_FULL) begin
                                r_s     <= '0;
                                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                                r_par   <= r_par ^ w_rx;
                                r_zero  <= r_zero & ~w_rx;
                                if (r_n == N_LAST_DATA) begin
                                    r_n     <= '0;
                                    r_state <= PARITY_EN ? PARITY : STOP;
                                end else begin
                                    r_n <= r_n + 1'b1;
                                end
                            end else begin
                                r_s <= r_s + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bus.i_s_tick) begin
                            if (r_s == S_FULL) begin
                                r_s     <= '0;
                                r_n     <= '0;
                                r_perr  <= ((r_par ^ w_rx) != PARITY_ODD);
                                r_zero  <= r_zero & ~w_rx;
                                r_state <= STOP;
                            end else begin
                                r_s <= r_s + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (bus.i_s_tick) begin
                            if (r_s == S_FULL) begin
                                r_s <= '0;
                                if (r_n == N_LAST_STOP) begin
                                    r_state      <= IDLE;
                                    r_n          <= '0;
                                    r_busy       <= 1'b0;
                                    r_done       <= 1'b1;
                                    r_out        <= r_shift;
                                    r_frame_err  <= r_ferr | ~w_rx;
                                    r_parity_err <= r_perr;
                                    r_break_det  <= w_brk;
                                    if (w_brk) r_armed <= w_rx;
                                end else begin
                                    r_n    <= r_n + 1'b1;
                                    r_ferr <= r_ferr | ~w_rx;
                                    if (r_n == '0) r_brk1 <= r_zero & ~w_rx;
                                end
                            end else begin
                                r_s <= r_s + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_frame_err  = r_frame_err;
    assign bus.o_parity_err = r_parity_err;
    assign bus.o_break_det  = r_break_det;
    assign bus.o_out        = r_out;
endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param in three configurations (8N1/16x, 7E1/8x, 8N2/16x),
// checked against a frame-level reference model of what each transmitted frame must report.
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) ifA ();
    uart_rx_param_if #(.DATA_BITS(7)) ifB ();
    uart_rx_param_if #(.DATA_BITS(8)) ifC ();

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
        dut_a (.clk(clk), .rstN(rstN), .bus(ifA.slave));
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1))
        dut_b (.clk(clk), .rstN(rstN), .bus(ifB.slave));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2))
        dut_c (.clk(clk), .rstN(rstN), .bus(ifC.slave));

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       bd;
    } rec_t;

    rec_t       qa[$];
    rec_t       qb[$];
    rec_t       qc[$];
    int         busy_a = 0;
    int         stray_a = 0;
    int         checks = 0;
    int         failures = 0;
    int         tick_div = 1;
    int         tph = 0;
    logic [7:0] last_a = 8'h00;

    always @(negedge clk) begin
        if (ifA.o_done) qa.push_back({1'b0, ifA.o_out, ifA.o_frame_err, ifA.o_parity_err, ifA.o_break_det});
        if (ifB.o_done) qb.push_back({2'b00, ifB.o_out, ifB.o_frame_err, ifB.o_parity_err, ifB.o_break_det});
        if (ifC.o_done) qc.push_back({1'b0, ifC.o_out, ifC.o_frame_err, ifC.o_parity_err, ifC.o_break_det});
        if (ifA.o_busy) busy_a = busy_a + 1;
        if (!ifA.o_done && (ifA.o_frame_err || ifA.o_parity_err || ifA.o_break_det)) stray_a = stray_a + 1;
    end

    always @(negedge clk) begin
        if (tph + 1 >= tick_div) tph = 0;
        else                     tph = tph + 1;
        ifA.i_s_tick = (tph == 0);
    end

    // Frame-level reference: what a receiver must report for the bits placed on the line.
    function automatic rec_t model(input logic [8:0] data, input int nbits, input bit par_en, input bit odd,
                                   input logic p, input int nstop, input logic [1:0] stops);
        rec_t       r;
        logic [8:0] d;
        int         ones;
        d    = data & ((9'h1 << nbits) - 9'h1);
        ones = $countones(d) + (par_en ? int'(p) : 0);
        r.data = d;
        r.pe   = par_en && ((ones % 2) != int'(odd));
        r.fe   = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        r.bd   = (d == 9'h0) && (!par_en || p == 1'b0) && (stops[0] == 1'b0);
        return r;
    endfunction

    function automatic logic [31:0] frame_vec(input logic [8:0] data, input int nbits, input bit par_en,
                                              input logic p, input int nstop, input logic [1:0] stops);
        logic [31:0] v;
        int          idx;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < nbits; i++) v[1 + i] = data[i];
        idx = 1 + nbits;
        if (par_en) begin
            v[idx] = p;
            idx = idx + 1;
        end
        for (int j = 0; j < nstop; j++) v[idx + j] = stops[j];
        return v;
    endfunction

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       ifA.i_in = v;
            1:       ifB.i_in = v;
            default: ifC.i_in = v;
        endcase
    endtask

    task automatic send_bits(input int sel, input logic [31:0] vec, input int len, input int bit_clks);
        for (int i = 0; i < len; i++) begin
            set_line(sel, vec[i]);
            repeat (bit_clks) @(negedge clk);
        end
        set_line(sel, 1'b1);
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifA.o_busy, ifA.o_done, ifA.o_frame_err, ifA.o_parity_err, ifA.o_break_det, ifA.o_out} !== 13'h0) begin
            failures++;
            $display("FAIL reset_a: got busy=%b done=%b out=%h required all 0", ifA.o_busy, ifA.o_done, ifA.o_out);
        end
        checks++;
        if ({ifB.o_busy, ifB.o_done, ifB.o_frame_err, ifB.o_parity_err, ifB.o_break_det, ifB.o_out} !== 12'h0) begin
            failures++;
            $display("FAIL reset_b: got busy=%b done=%b out=%h required all 0", ifB.o_busy, ifB.o_done, ifB.o_out);
        end
        checks++;
        if ({ifC.o_busy, ifC.o_done, ifC.o_frame_err, ifC.o_parity_err, ifC.o_break_det, ifC.o_out} !== 13'h0) begin
            failures++;
            $display("FAIL reset_c: got busy=%b done=%b out=%h required all 0", ifC.o_busy, ifC.o_done, ifC.o_out);
        end
        rstN = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_8n1;
        int         base;
        int         b0;
        int         s0;
        int         bc;
        logic [7:0] d;
        rec_t       expq[$];
        base = qa.size();
        b0   = busy_a;
        s0   = stray_a;
        expq.push_back(model(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11));
        send_bits(0, frame_vec(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11), 10, 16);
        repeat (16) @(negedge clk);
        bc = busy_a - b0;
        checks++;
        if (bc < 150 || bc > 154) begin
            failures++;
            $display("FAIL a_busy_len: got %0d clks required 150..154", bc);
        end
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            expq.push_back(model({1'b0, d}, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11));
            send_bits(0, frame_vec({1'b0, d}, 8, 1'b0, 1'b0, 1, 2'b11), 10, 16);
            repeat (16 * $urandom_range(0, 2)) @(negedge clk);
            last_a = d;
        end
        repeat (32) @(negedge clk);
        checks++;
        if (qa.size() - base != expq.size()) begin
            failures++;
            $display("FAIL a_count: got %0d done pulses required %0d", qa.size() - base, expq.size());
        end else begin
            for (int k = 0; k < expq.size(); k++) begin
                checks++;
                if (qa[base + k] !== expq[k]) begin
                    failures++;
                    $display("FAIL a_frame%0d: got %h required %h", k, qa[base + k], expq[k]);
                end
            end
        end
        checks++;
        if (stray_a != s0) begin
            failures++;
            $display("FAIL a_flags_without_done: got %0d cycles required 0", stray_a - s0);
        end
    endtask

    task automatic test_slow_tick;
        int         base;
        logic [7:0] d;
        rec_t       expq[$];
        tick_div = 2;
        repeat (8) @(negedge clk);
        base = qa.size();
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            expq.push_back(model({1'b0, d}, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11));
            send_bits(0, frame_vec({1'b0, d}, 8, 1'b0, 1'b0, 1, 2'b11), 10, 32);
            repeat (32 * $urandom_range(0, 1)) @(negedge clk);
            last_a = d;
        end
        repeat (64) @(negedge clk);
        checks++;
        if (qa.size() - base != expq.size()) begin
            failures++;
            $display("FAIL slow_count: got %0d done pulses required %0d", qa.size() - base, expq.size());
        end else begin
            for (int k = 0; k < expq.size(); k++) begin
                checks++;
                if (qa[base + k] !== expq[k]) begin
                    failures++;
                    $display("FAIL slow_frame%0d: got %h required %h", k, qa[base + k], expq[k]);
                end
            end
        end
        tick_div = 1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_false_start;
        int base;
        int b0;
        base = qa.size();
        b0   = busy_a;
        set_line(0, 1'b0);
        repeat (4) @(negedge clk);
        set_line(0, 1'b1);
        repeat (48) @(negedge clk);
        checks++;
        if (qa.size() != base) begin
            failures++;
            $display("FAIL glitch_done: got %0d done pulses required 0", qa.size() - base);
        end
        checks++;
        if (busy_a - b0 != 8) begin
            failures++;
            $display("FAIL glitch_busy: got %0d busy clks required 8", busy_a - b0);
        end
        checks++;
        if (ifA.o_out !== last_a) begin
            failures++;
            $display("FAIL glitch_out: got %h required %h", ifA.o_out, last_a);
        end
    endtask

    task automatic test_parity;
        int         base;
        logic [6:0] d;
        logic       p;
        rec_t       expq[$];
        base = qb.size();
        expq.push_back(model(9'h041, 7, 1'b1, 1'b0, 1'b1, 1, 2'b11));
        send_bits(1, frame_vec(9'h041, 7, 1'b1, 1'b1, 1, 2'b11), 10, 8);
        repeat (16) @(negedge clk);
        expq.push_back(model(9'h041, 7, 1'b1, 1'b0, 1'b0, 1, 2'b11));
        send_bits(1, frame_vec(9'h041, 7, 1'b1, 1'b0, 1, 2'b11), 10, 8);
        repeat (16) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            d = 7'($urandom);
            p = 1'($urandom);
            expq.push_back(model({2'b00, d}, 7, 1'b1, 1'b0, p, 1, 2'b11));
            send_bits(1, frame_vec({2'b00, d}, 7, 1'b1, p, 1, 2'b11), 10, 8);
            repeat (8 * $urandom_range(0, 2)) @(negedge clk);
        end
        repeat (32) @(negedge clk);
        checks++;
        if (qb.size() - base != expq.size()) begin
            failures++;
            $display("FAIL b_count: got %0d done pulses required %0d", qb.size() - base, expq.size());
        end else begin
            for (int k = 0; k < expq.size(); k++) begin
                checks++;
                if (qb[base + k] !== expq[k]) begin
                    failures++;
                    $display("FAIL b_frame%0d: got %h required %h", k, qb[base + k], expq[k]);
                end
            end
        end
    endtask

    task automatic test_two_stop;
        int         base;
        logic [7:0] d;
        logic [1:0] st;
        rec_t       expq[$];
        base = qc.size();
        expq.push_back(model(9'h05A, 8, 1'b0, 1'b0, 1'b0, 2, 2'b01));
        send_bits(2, frame_vec(9'h05A, 8, 1'b0, 1'b0, 2, 2'b01), 11, 16);
        repeat (32) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(1, 255));
            case ($urandom_range(0, 3))
                0:       st = 2'b01;
                1:       st = 2'b10;
                default: st = 2'b11;
            endcase
            expq.push_back(model({1'b0, d}, 8, 1'b0, 1'b0, 1'b0, 2, st));
            send_bits(2, frame_vec({1'b0, d}, 8, 1'b0, 1'b0, 2, st), 11, 16);
            repeat (16 * $urandom_range(1, 2)) @(negedge clk);
        end
        repeat (32) @(negedge clk);
        checks++;
        if (qc.size() - base != expq.size()) begin
            failures++;
            $display("FAIL c_count: got %0d done pulses required %0d", qc.size() - base, expq.size());
        end else begin
            for (int k = 0; k < expq.size(); k++) begin
                checks++;
                if (qc[base + k] !== expq[k]) begin
                    failures++;
                    $display("FAIL c_frame%0d: got %h required %h", k, qc[base + k], expq[k]);
                end
            end
        end
    endtask

    task automatic test_break;
        int         base;
        logic [7:0] d;
        rec_t       eb;
        rec_t       er;
        base = qa.size();
        eb   = model(9'h000, 8, 1'b0, 1'b0, 1'b0, 1, 2'b00);
        set_line(0, 1'b0);
        repeat (12 * 16) @(negedge clk);
        set_line(0, 1'b1);
        repeat (3 * 16) @(negedge clk);
        checks++;
        if (qa.size() - base != 1) begin
            failures++;
            $display("FAIL break_count: got %0d done pulses required 1", qa.size() - base);
        end else begin
            checks++;
            if (qa[base] !== eb) begin
                failures++;
                $display("FAIL break_frame: got %h required %h", qa[base], eb);
            end
        end
        last_a = 8'h00;
        d  = 8'($urandom_range(1, 255));
        er = model({1'b0, d}, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11);
        send_bits(0, frame_vec({1'b0, d}, 8, 1'b0, 1'b0, 1, 2'b11), 10, 16);
        repeat (32) @(negedge clk);
        checks++;
        if (qa.size() - base != 2) begin
            failures++;
            $display("FAIL break_recover_count: got %0d done pulses required 2", qa.size() - base);
        end else begin
            checks++;
            if (qa[base + 1] !== er) begin
                failures++;
                $display("FAIL break_recover_frame: got %h required %h", qa[base + 1], er);
            end
        end
        last_a = d;
    endtask

    task automatic test_back_to_back;
        int          base;
        logic [31:0] v3;
        rec_t        e1;
        rec_t        e2;
        base = qa.size();
        e1 = model(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11);
        e2 = model(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11);
        send_bits(0, frame_vec(9'h03C, 8, 1'b0, 1'b0, 1, 2'b11), 10, 16);
        send_bits(0, frame_vec(9'h0C3, 8, 1'b0, 1'b0, 1, 2'b11), 10, 16);
        v3 = frame_vec({1'b0, 8'($urandom)}, 8, 1'b0, 1'b0, 1, 2'b11);
        for (int i = 0; i < 4; i++) begin
            set_line(0, v3[i]);
            repeat (16) @(negedge clk);
        end
        checks++;
        if (ifA.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_mid: got %b required 1", ifA.o_busy);
        end
        ifA.i_enabled = 1'b0;
        @(negedge clk);
        checks++;
        if (ifA.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_abort_busy: got %b required 0", ifA.o_busy);
        end
        set_line(0, 1'b1);
        repeat (3 * 16) @(negedge clk);
        ifA.i_enabled = 1'b1;
        repeat (32) @(negedge clk);
        checks++;
        if (qa.size() - base != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses required 2", qa.size() - base);
        end else begin
            checks++;
            if (qa[base] !== e1) begin
                failures++;
                $display("FAIL b2b_first: got %h required %h", qa[base], e1);
            end
            checks++;
            if (qa[base + 1] !== e2) begin
                failures++;
                $display("FAIL b2b_second: got %h required %h", qa[base + 1], e2);
            end
        end
        last_a = 8'hC3;
        checks++;
        if (ifA.o_out !== last_a) begin
            failures++;
            $display("FAIL b2b_out_hold: got %h required %h", ifA.o_out, last_a);
        end
    endtask

    task automatic test_disabled;
        int base;
        int b0;
        base = qa.size();
        b0   = busy_a;
        ifA.i_enabled = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(0, frame_vec(9'h096, 8, 1'b0, 1'b0, 1, 2'b11), 10, 16);
        repeat (32) @(negedge clk);
        checks++;
        if (qa.size() != base || busy_a != b0) begin
            failures++;
            $display("FAIL disabled: got %0d done %0d busy clks required 0 and 0", qa.size() - base, busy_a - b0);
        end
        checks++;
        if (ifA.o_out !== last_a) begin
            failures++;
            $display("FAIL disabled_out: got %h required %h", ifA.o_out, last_a);
        end
        ifA.i_enabled = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_async_reset;
        int base;
        base = qa.size();
        set_line(0, 1'b0);
        repeat (3 * 16) @(negedge clk);
        checks++;
        if (ifA.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_busy_before: got %b required 1", ifA.o_busy);
        end
        #3 rstN = 1'b0;
        #1;
        checks++;
        if ({ifA.o_busy, ifA.o_done, ifA.o_frame_err, ifA.o_parity_err, ifA.o_break_det, ifA.o_out} !== 13'h0) begin
            failures++;
            $display("FAIL areset_outputs: got busy=%b out=%h required all 0", ifA.o_busy, ifA.o_out);
        end
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (4) @(negedge clk);
        rstN = 1'b1;
        repeat (3 * 16) @(negedge clk);
        last_a = 8'h00;
        checks++;
        if (qa.size() != base || ifA.o_out !== last_a) begin
            failures++;
            $display("FAIL areset_discard: got %0d done out=%h required 0 done out=%h", qa.size() - base, ifA.o_out, last_a);
        end
    endtask

    initial begin
        rstN          = 1'b0;
        ifA.i_enabled = 1'b1;
        ifB.i_enabled = 1'b1;
        ifC.i_enabled = 1'b1;
        ifA.i_in      = 1'b1;
        ifB.i_in      = 1'b1;
        ifC.i_in      = 1'b1;
        ifB.i_s_tick  = 1'b1;
        ifC.i_s_tick  = 1'b1;
        test_reset();
        test_8n1();
        test_slow_tick();
        test_false_start();
        test_parity();
        test_two_stop();
        test_break();
        test_back_to_back();
        test_disabled();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
